nv_ram_rwsp_32x256_fifo_ctrl: RTL and testbench
===============================================

// Module: nv_ram_rwsp_32x256_fifo_ctrl
// PURPOSE
// Valid/ready FIFO sequencer for one nv_ram_rwsp_32x256 instance (32 x 256b, 1W/1R).
// Owns the write and read pointers and drives the RAM's ra/re/ore/wa/we.
// Absorbs the RAM's 2-stage read (re latches ra_d; ore latches dout) with no extra data storage.
// Keeps full read throughput (1 word/clk) under back-pressure.
// PARAMETERS
// DEPTH  32   RAM entries; power of 2; pointers wrap modulo DEPTH
// AW     5    log2(DEPTH); pointer and RAM address width
// DW     256  payload width; equals RAM data width
// PORTS
// nvdla_core_clk   in   1      core clock
// nvdla_core_rstn  in   1      async active-low reset
// clr              in   1      sync flush; drops all stored and in-flight entries
// wr_pvld          in   1      write request valid
// wr_prdy          out  1      write accept; wr_acc = wr_pvld & wr_prdy
// wr_pd            in   DW     write payload
// rd_pvld          out  1      read data valid
// rd_prdy          in   1      read consumer ready; rd_acc = rd_pvld & rd_prdy
// rd_pd            out  DW     read payload; wire from ram_dout
// fifo_cnt         out  AW+1   entries written and not yet rd_acc'd (0..DEPTH)
// ram_wa           out  AW     RAM write address (= wr_ptr)
// ram_we           out  1      RAM write enable (= wr_acc)
// ram_di           out  DW     RAM write data (= wr_pd)
// ram_ra           out  AW     RAM read address (= rd_ptr)
// ram_re           out  1      RAM read-address latch enable
// ram_ore          out  1      RAM output-register enable
// ram_dout         in   DW     RAM registered read data
// pwrbus_ram_pd    in   32     pass-through to ram_pwrbus_ram_pd
// ram_pwrbus_ram_pd out 32     to RAM
// BEHAVIOUR
// State regs: wr_ptr, rd_ptr (AW), occ (AW+1), s1_vld (ra_d holds live addr), s2_vld (dout_r holds live word).
// Reset: all regs 0. Outputs after reset: wr_prdy=1, rd_pvld=0, ram_we=0, ram_re=0, ram_ore=0, fifo_cnt=0.
// RAM dout_r is not reset. rd_pvld gating alone guarantees no X is presented as valid.
// pend = occ - s1_vld - s2_vld: entries written but not yet issued to the RAM.
// wr_prdy = !clr & (occ != DEPTH).
// rd_pvld = s2_vld & !clr.
// ram_ore = !clr & s1_vld & (!s2_vld | rd_prdy).
// ram_re  = !clr & (pend != 0) & (!s1_vld | ram_ore).
// ram_re=0 holds ra_d, which keeps a stalled s1 word stable.
// ram_ore=0 holds dout_r; rd_pd stays stable while rd_pvld & !rd_prdy.
// Per clk:
//   wr_acc -> wr_ptr+1.
//   ram_re -> rd_ptr+1.
//   s1_vld <= ram_re | (s1_vld & !ram_ore).
//   s2_vld <= ram_ore | (s2_vld & !rd_prdy).
//   occ <= occ + wr_acc - rd_acc.
//   Simultaneous wr_acc and rd_acc leaves occ unchanged.
// Pointers wrap DEPTH-1 -> 0 naturally; occ distinguishes full from empty.
// Latency: wr_acc in clk t -> earliest ram_re in t+1 -> ram_ore in t+2 -> rd_pvld in t+3. No write-to-read bypass.
// Full: occ=DEPTH -> wr_prdy=0. A same-cycle rd_acc does not raise wr_prdy until the next clk (no combinational ready path).
// Empty: pend=0 -> ram_re=0. The pipeline drains s1/s2 normally.
// Address reuse: a slot is rewritable only after its word is rd_acc'd (occ-based), so in-flight reads never race a write.
// clr=1: next clk wr_ptr=rd_ptr=occ=0 and s1_vld=s2_vld=0. All wr/rd strobes masked during the clr cycle.
// Async reset mid-operation: same end state as clr, effective immediately.
// fifo_cnt = occ (registered).
// TESTING
// 1 Reset, idle 10 clk -> wr_prdy=1, rd_pvld=0, ram_we/re/ore=0, fifo_cnt=0.
// 2 Single write 0xA5 (replicated) at clk t, rd_prdy=1 -> ram_re t+1, ram_ore t+2, rd_pvld t+3 with 0xA5..; fifo_cnt 1 then 0.
// 3 rd_prdy=0, write 32 words val=i -> wr_prdy=0 after 32nd, fifo_cnt=32. Write 33 held.
//   Then rd_prdy=1 -> reads 0..31 in order, then word 33. rd_ptr wraps to 0 cleanly.
// 4 wr_pvld=rd_prdy=1 for 200 words -> 1 word/clk sustained after 3-clk fill, in-order, fifo_cnt constant.
// 5 Random rd_prdy (50%), random wr_pvld, 1000 words -> scoreboard match. rd_pd stable whenever rd_pvld & !rd_prdy.
// 6 10 entries stored, s1/s2 busy, pulse clr -> next clk fifo_cnt=0, rd_pvld=0.
//   Then write 0x3C -> 0x3C returned at t+3, no stale word. Repeat with rstn pulse instead of clr.

Source files
------------

// File: rtl/nv_ram_rwsp_32x256_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// nv_ram_rwsp_32x256_fifo_ctrl
//   Valid/ready FIFO sequencer wrapped around one 32x256 1W/1R RAM with a
//   two-stage read (re latches the read address, ore latches the data word).
//   The RAM's own address and output registers act as the read pipeline, so
//   the block holds no payload storage of its own. It still sustains one word
//   per clock under back-pressure.
//
// Ports
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   clr                              : synchronous flush of all entries
//   wr_pvld / wr_prdy / wr_pd        : write side handshake + payload
//   rd_pvld / rd_prdy / rd_pd        : read side handshake + payload
//   fifo_cnt                         : entries written and not yet read out
//   ram_wa/ram_we/ram_di             : RAM write port
//   ram_ra/ram_re/ram_ore/ram_dout   : RAM read port (2-stage)
//   pwrbus_ram_pd -> ram_pwrbus_ram_pd : power bus pass-through
// -----------------------------------------------------------------------------
module nv_ram_rwsp_32x256_fifo_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 256
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          clr,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW:0]   fifo_cnt,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  output logic          ram_ore,
  input  logic [DW-1:0] ram_dout,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic [31:0]   ram_pwrbus_ram_pd
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          s1_vld_q, s1_vld_d;  // RAM address register holds a live address
  logic          s2_vld_q, s2_vld_d;  // RAM output register holds a live word
  logic [AW:0]   pend;
  logic          wr_acc, rd_acc;

  // Entries in the RAM that have not yet been issued into the read pipeline.
  assign pend = occ_q - (AW+1)'(s1_vld_q) - (AW+1)'(s2_vld_q);

  assign wr_prdy = !clr && (occ_q != FULL);
  assign rd_pvld = s2_vld_q && !clr;
  assign wr_acc  = wr_pvld && wr_prdy;
  assign rd_acc  = rd_pvld && rd_prdy;

  // Advance s1->s2 whenever s2 is empty or being consumed this cycle; issue a
  // new address whenever s1 is empty or moving on. Holding re/ore low freezes
  // the RAM registers, which is what keeps rd_pd stable while stalled.
  assign ram_ore = !clr && s1_vld_q && (!s2_vld_q || rd_prdy);
  assign ram_re  = !clr && (pend != '0) && (!s1_vld_q || ram_ore);

  assign ram_wa            = wr_ptr_q;
  assign ram_we            = wr_acc;
  assign ram_di            = wr_pd;
  assign ram_ra            = rd_ptr_q;
  assign rd_pd             = ram_dout;
  assign fifo_cnt          = occ_q;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d = rd_ptr_q + AW'(ram_re);
    occ_d    = occ_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
    s1_vld_d = ram_re  || (s1_vld_q && !ram_ore);
    s2_vld_d = ram_ore || (s2_vld_q && !rd_prdy);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

endmodule

// File: tb/tb_nv_ram_rwsp_32x256_fifo_ctrl.sv
module tb_nv_ram_rwsp_32x256_fifo_ctrl;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 256;

  logic          clk = 1'b0;
  logic          rstn, clr, wr_pvld, wr_prdy, rd_pvld, rd_prdy;
  logic [DW-1:0] wr_pd, rd_pd, ram_di, ram_dout;
  logic [AW:0]   fifo_cnt;
  logic [AW-1:0] ram_wa, ram_ra;
  logic          ram_we, ram_re, ram_ore;
  logic [31:0]   pwr_i, pwr_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nv_ram_rwsp_32x256_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .clr(clr),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .fifo_cnt(fifo_cnt),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore), .ram_dout(ram_dout),
    .pwrbus_ram_pd(pwr_i), .ram_pwrbus_ram_pd(pwr_o)
  );

  // Behavioural 2-stage RAM: re latches the address, ore latches mem[ra_d].
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra_d;
  logic [DW-1:0] dout_r;
  assign ram_dout = dout_r;
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_d <= ram_ra;
    if (ram_ore) dout_r <= mem[ra_d];
  end

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Reference model: the FIFO is an ordered queue of accepted words; the
  // count is its length; reads must return the head in order.
  logic [DW-1:0] q[$];
  int            n_wr = 0, n_rd = 0;
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_pd;
  logic          exp_prdy;

  always @(negedge clk) begin
    if (!rstn) begin
      q.delete();
      stall_q = 1'b0;
    end else begin
      exp_prdy = !clr && (q.size() != DEPTH);
      chk1("wr_prdy", wr_prdy, exp_prdy);
      chkw("fifo_cnt", DW'(fifo_cnt), DW'(q.size()));
      chk1("ram_we", ram_we, wr_pvld && exp_prdy);
      if (stall_q && !clr) begin
        chk1("stall_hold_vld", rd_pvld, 1'b1);
        chkw("stall_hold_pd", rd_pd, stall_pd);
      end
      if (clr) chkw("clr_mask", DW'({rd_pvld, ram_re, ram_ore}), '0);
      if (rd_pvld && rd_prdy) begin
        chk1("rd_from_empty", q.size() == 0, 1'b0);
        if (q.size() != 0) begin
          chkw("rd_pd", rd_pd, q[0]);
          void'(q.pop_front());
          n_rd++;
        end
      end
      if (wr_pvld && exp_prdy) begin
        q.push_back(wr_pd);
        n_wr++;
      end
      if (clr) q.delete();
      stall_q  = rd_pvld && !rd_prdy && !clr;
      stall_pd = rd_pd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One word in, checked against the fixed write->re->ore->rd_pvld latency.
  task automatic single_rt(input string tag, input logic [7:0] b);
    tick(); rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = {32{b}};
    @(negedge clk); chk1({tag, "_we_t0"}, ram_we, 1'b1);
    tick(); wr_pvld = 1'b0;
    @(negedge clk); chk1({tag, "_re_t1"}, ram_re, 1'b1); chk1({tag, "_ore_t1"}, ram_ore, 1'b0);
    chkw({tag, "_cnt_t1"}, DW'(fifo_cnt), DW'(1));
    tick();
    @(negedge clk); chk1({tag, "_ore_t2"}, ram_ore, 1'b1); chk1({tag, "_vld_t2"}, rd_pvld, 1'b0);
    chk1({tag, "_re_t2"}, ram_re, 1'b0);
    tick();
    @(negedge clk); chk1({tag, "_vld_t3"}, rd_pvld, 1'b1); chkw({tag, "_pd_t3"}, rd_pd, {32{b}});
    tick();
    @(negedge clk); chk1({tag, "_vld_t4"}, rd_pvld, 1'b0); chkw({tag, "_cnt_t4"}, DW'(fifo_cnt), '0);
  endtask

  task automatic drain(input string tag, input bit rand_rdy);
    for (int i = 0; i < 400 && (fifo_cnt != '0 || rd_pvld); i++) begin
      tick(); wr_pvld = 1'b0;
      rd_prdy = rand_rdy ? 1'($urandom % 2) : 1'b1;
      @(negedge clk);
    end
    chkw({tag, "_drained"}, DW'(fifo_cnt), '0);
  endtask

  task automatic fill10();
    for (int i = 0; i < 10; i++) begin
      tick(); rd_prdy = 1'b0; wr_pvld = 1'b1; wr_pd = rnd();
    end
    for (int i = 0; i < 4; i++) begin
      tick(); wr_pvld = 1'b0;
    end
    @(negedge clk);
    chkw("fill_cnt", DW'(fifo_cnt), DW'(10));
    chk1("fill_s2_busy", rd_pvld, 1'b1);
  endtask

  initial begin
    int r0, sent, cyc;
    rstn = 1'b0; clr = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
    pwr_i = $urandom;
    repeat (3) tick();
    rstn = 1'b1;

    // 1: idle after reset
    repeat (10) tick();
    @(negedge clk);
    chk1("rst_wr_prdy", wr_prdy, 1'b1);
    chk1("rst_rd_pvld", rd_pvld, 1'b0);
    chkw("rst_strobes", DW'({ram_we, ram_re, ram_ore}), '0);
    chkw("rst_cnt", DW'(fifo_cnt), '0);
    chkw("pwrbus", DW'(pwr_o), DW'(pwr_i));

    // 2: single word latency
    single_rt("single", 8'hA5);

    // 3: fill to full with back-pressure, one held write, then in-order drain
    r0 = n_rd;
    for (int i = 0; i < DEPTH; i++) begin
      tick(); rd_prdy = 1'b0; wr_pvld = 1'b1; wr_pd = DW'(i);
      @(negedge clk); chk1("full_fill_prdy", wr_prdy, 1'b1);
    end
    tick(); wr_pd = DW'(DEPTH);
    @(negedge clk);
    chk1("full_prdy_low", wr_prdy, 1'b0);
    chkw("full_cnt", DW'(fifo_cnt), DW'(DEPTH));
    repeat (3) tick();
    @(negedge clk); chk1("full_still_held", wr_prdy, 1'b0);
    tick(); rd_prdy = 1'b1;
    @(negedge clk); chk1("full_same_cycle_prdy", wr_prdy, 1'b0);
    for (int i = 0; i < 20 && !wr_prdy; i++) begin tick(); @(negedge clk); end
    chk1("full_held_accepted", wr_prdy, 1'b1);
    tick(); wr_pvld = 1'b0;
    drain("full", 1'b0);
    chkw("full_read_count", DW'(n_rd - r0), DW'(DEPTH + 1));

    // 4: streaming at one word per clock
    for (int c = 0; c < 200; c++) begin
      tick(); wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = rnd();
      @(negedge clk);
      if (c >= 3) begin
        chk1("stream_vld", rd_pvld, 1'b1);
        chkw("stream_cnt", DW'(fifo_cnt), DW'(3));
      end
    end
    drain("stream", 1'b0);

    // 5: random traffic against the queue model
    r0 = n_rd; sent = 0; cyc = 0;
    while (sent < 1000 && cyc < 8000) begin
      tick(); cyc++;
      wr_pvld = 1'($urandom % 2); wr_pd = rnd(); rd_prdy = 1'($urandom % 2);
      @(negedge clk);
      if (wr_pvld && wr_prdy) sent++;
    end
    chkw("rand_sent", DW'(sent), DW'(1000));
    drain("rand", 1'b1);
    chkw("rand_read_count", DW'(n_rd - r0), DW'(1000));

    // 6a: flush with clr while the pipeline is busy; strobes must be masked
    fill10();
    tick(); clr = 1'b1; wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = rnd();
    @(negedge clk);
    chk1("clr_wr_prdy", wr_prdy, 1'b0);
    chk1("clr_we", ram_we, 1'b0);
    tick(); clr = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0;
    @(negedge clk);
    chkw("clr_cnt", DW'(fifo_cnt), '0);
    chk1("clr_vld", rd_pvld, 1'b0);
    single_rt("post_clr", 8'h3C);

    // 6b: same with an asynchronous reset pulse mid-cycle
    fill10();
    tick(); rstn = 1'b0;
    #1;
    chkw("arst_cnt", DW'(fifo_cnt), '0);
    chk1("arst_vld", rd_pvld, 1'b0);
    chk1("arst_prdy", wr_prdy, 1'b1);
    tick(); rstn = 1'b1;
    single_rt("post_rst", 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
